// File: rtl/alu_sched_pkg.sv
// rtl/alu_sched_pkg.sv - shared state and unit-select definitions for the ALU request scheduler
package alu_sched_pkg;

    typedef enum logic [1:0] {
        SCHED_IDLE  = 2'd0,
        SCHED_ISSUE = 2'd1,
        SCHED_WAIT  = 2'd2,
        SCHED_RESP  = 2'd3
    } sched_state_e;

    // fn[3:2] selects the ALU unit; the ALU decoder uses the same encoding
    localparam logic [1:0] UNIT_ARITH = 2'b00;
    localparam logic [1:0] UNIT_LOGIC = 2'b01;
    localparam logic [1:0] UNIT_CMP   = 2'b10;
    localparam logic [1:0] UNIT_SHIFT = 2'b11;

    function automatic logic [1:0] unit_sel(input logic [3:0] fn);
        return fn[3:2];
    endfunction

endpackage

// File: rtl/alu_req_sched_if.sv
// rtl/alu_req_sched_if.sv - client request/response channels of the ALU request scheduler
interface alu_req_sched_if #(
    parameter int DATA_W = 16,
    parameter int RES_W  = 32
);
    logic              req0_valid;
    logic              req0_ready;
    logic [3:0]        req0_fn;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;

    logic              req1_valid;
    logic              req1_ready;
    logic [3:0]        req1_fn;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;

    logic              resp_valid;
    logic              resp_ready;
    logic              resp_id;
    logic [RES_W-1:0]  resp_data;
    logic              resp_carry;
    logic              resp_err;

    modport master (
        output req0_valid, req0_fn, req0_a, req0_b,
        output req1_valid, req1_fn, req1_a, req1_b,
        output resp_ready,
        input  req0_ready, req1_ready,
        input  resp_valid, resp_id, resp_data, resp_carry, resp_err
    );

    modport slave (
        input  req0_valid, req0_fn, req0_a, req0_b,
        input  req1_valid, req1_fn, req1_a, req1_b,
        input  resp_ready,
        output req0_ready, req1_ready,
        output resp_valid, resp_id, resp_data, resp_carry, resp_err
    );
endinterface

// File: rtl/alu_req_sched_rr_arb2.sv
// rtl/alu_req_sched_rr_arb2.sv - two-way round-robin grant from valid bits and last served id
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_id,
    output logic [1:0] grant
);
    // On a tie the requester not served last wins
    always_comb begin
        grant = 2'b00;
        if (valid[0] && (!valid[1] || last_id)) begin
            grant = 2'b01;
        end else if (valid[1]) begin
            grant = 2'b10;
        end
    end
endmodule

// File: rtl/alu_req_sched.sv
// rtl/alu_req_sched.sv - round-robin request scheduler owning the shared signed ALU inputs
module alu_req_sched
    import alu_sched_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int RES_W   = 32,
    parameter int TIMEOUT = 4
) (
    input  logic              clk,
    input  logic              rst,
    alu_req_sched_if.slave    bus,
    output logic [DATA_W-1:0] alu_A,
    output logic [DATA_W-1:0] alu_B,
    output logic [3:0]        alu_fn,
    input  logic [RES_W-1:0]  arith_out,
    input  logic [15:0]       logic_out,
    input  logic [15:0]       cmp_out,
    input  logic [15:0]       shift_out,
    input  logic              arith_flag,
    input  logic              logic_flag,
    input  logic              cmp_flag,
    input  logic              shift_flag,
    input  logic              carry_out
);
    localparam logic [1:0] ST_IDLE  = 2'(SCHED_IDLE);
    localparam logic [1:0] ST_ISSUE = 2'(SCHED_ISSUE);
    localparam logic [1:0] ST_WAIT  = 2'(SCHED_WAIT);
    localparam logic [1:0] ST_RESP  = 2'(SCHED_RESP);

    localparam int               CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

    logic [1:0]       state;
    logic             last_id;
    logic             cur_id;
    logic [CNT_W-1:0] cnt;
    logic [RES_W-1:0] resp_data_q;
    logic             resp_carry_q;
    logic             resp_err_q;

    logic [1:0]       grant;
    logic             in_idle;
    logic             accept;
    logic             unit_hit;
    logic [RES_W-1:0] unit_data;
    logic             unit_carry;

    rr_arb2 u_arb (
        .valid   ({bus.req1_valid, bus.req0_valid}),
        .last_id (last_id),
        .grant   (grant)
    );

    assign in_idle        = (state == ST_IDLE) && !rst;
    assign accept         = in_idle && (grant != 2'b00);
    assign bus.req0_ready = in_idle && grant[0];
    assign bus.req1_ready = in_idle && grant[1];

    assign bus.resp_valid = (state == ST_RESP);
    assign bus.resp_id    = cur_id;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_carry = resp_carry_q;
    assign bus.resp_err   = resp_err_q;

    // alu_fn doubles as the latched opcode, so the unit select follows it directly
    always_comb begin
        unit_hit   = 1'b0;
        unit_data  = '0;
        unit_carry = 1'b0;
        case (unit_sel(alu_fn))
            UNIT_ARITH: begin
                unit_hit   = arith_flag;
                unit_data  = arith_out;
                unit_carry = carry_out;
            end
            UNIT_LOGIC: begin
                unit_hit  = logic_flag;
                unit_data = RES_W'(logic_out);
            end
            UNIT_CMP: begin
                unit_hit  = cmp_flag;
                unit_data = RES_W'(cmp_out);
            end
            UNIT_SHIFT: begin
                unit_hit  = shift_flag;
                unit_data = RES_W'(shift_out);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            last_id      <= 1'b1;
            cur_id       <= 1'b0;
            cnt          <= '0;
            alu_A        <= '0;
            alu_B        <= '0;
            alu_fn       <= '0;
            resp_data_q  <= '0;
            resp_carry_q <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        cur_id <= grant[1];
                        alu_fn <= grant[1] ? bus.req1_fn : bus.req0_fn;
                        alu_A  <= grant[1] ? bus.req1_a  : bus.req0_a;
                        alu_B  <= grant[1] ? bus.req1_b  : bus.req0_b;
                        state  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    cnt   <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A flag arriving on the limit cycle still counts as a result
                    if (unit_hit) begin
                        resp_data_q  <= unit_data;
                        resp_carry_q <= unit_carry;
                        resp_err_q   <= 1'b0;
                        state        <= ST_RESP;
                    end else if (cnt == CNT_LIMIT) begin
                        resp_data_q  <= '0;
                        resp_carry_q <= 1'b0;
                        resp_err_q   <= 1'b1;
                        state        <= ST_RESP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (bus.resp_ready) begin
                        last_id <= cur_id;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_req_sched.sv
// tb/tb_alu_req_sched.sv - self-checking bench for alu_req_sched with a behavioural ALU stub
module tb_alu_req_sched;
    import alu_sched_pkg::*;

    localparam int DATA_W  = 16;
    localparam int RES_W   = 32;
    localparam int TIMEOUT = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_req_sched_if #(.DATA_W(DATA_W), .RES_W(RES_W)) bus ();

    logic [15:0] alu_A, alu_B;
    logic [3:0]  alu_fn;
    logic [31:0] arith_out;
    logic [15:0] logic_out, cmp_out, shift_out;
    logic        arith_flag, logic_flag, cmp_flag, shift_flag, carry_out;

    alu_req_sched #(.DATA_W(DATA_W), .RES_W(RES_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .alu_A(alu_A), .alu_B(alu_B), .alu_fn(alu_fn),
        .arith_out(arith_out), .logic_out(logic_out), .cmp_out(cmp_out), .shift_out(shift_out),
        .arith_flag(arith_flag), .logic_flag(logic_flag), .cmp_flag(cmp_flag),
        .shift_flag(shift_flag), .carry_out(carry_out)
    );

    typedef struct packed {
        logic [31:0] arith;
        logic [15:0] lo;
        logic [15:0] cm;
        logic [15:0] sh;
        logic        c;
    } alu_res_t;

    function automatic alu_res_t alu_calc(input logic [3:0] fn, input logic [15:0] a, input logic [15:0] b);
        alu_res_t r;
        int sa, sb;
        logic [16:0] s;
        sa = int'($signed(a));
        sb = int'($signed(b));
        case (fn[1:0])
            2'd0: r.arith = 32'(sa + sb);
            2'd1: r.arith = 32'(sa - sb);
            2'd2: r.arith = 32'(sa * sb);
            default: r.arith = 32'(-sa);
        endcase
        case (fn[1:0])
            2'd0: r.lo = a & b;
            2'd1: r.lo = a | b;
            2'd2: r.lo = a ^ b;
            default: r.lo = ~a;
        endcase
        case (fn[1:0])
            2'd0: r.cm = {15'b0, sa < sb};
            2'd1: r.cm = {15'b0, sa == sb};
            2'd2: r.cm = {15'b0, sa > sb};
            default: r.cm = {15'b0, sa >= sb};
        endcase
        case (fn[1:0])
            2'd0: r.sh = a << b[3:0];
            2'd1: r.sh = a >> b[3:0];
            2'd2: r.sh = 16'($signed(a) >>> b[3:0]);
            default: r.sh = {a[14:0], a[15]};
        endcase
        s = {1'b0, a} + {1'b0, b};
        r.c = s[16];
        return r;
    endfunction

    // ALU stub: registers its inputs every cycle, flag of the selected unit after flag_delay
    int          flag_delay  = 0;
    logic [3:0]  flag_en     = 4'hF;
    logic [3:0]  flag_force  = 4'h0;
    logic        force_carry = 1'b0;
    logic [15:0] a_r = '0, b_r = '0;
    logic [3:0]  fn_r = '0;
    int          dly = 0;
    logic        hs_d = 1'b0;
    alu_res_t    cur;

    always @(posedge clk) begin
        a_r  <= alu_A;
        b_r  <= alu_B;
        fn_r <= alu_fn;
        if (hs_d) dly <= flag_delay;
        else if (dly > 0) dly <= dly - 1;
        hs_d <= !rst && ((bus.req0_valid && bus.req0_ready) || (bus.req1_valid && bus.req1_ready));
    end

    assign cur        = alu_calc(fn_r, a_r, b_r);
    assign arith_out  = cur.arith;
    assign logic_out  = cur.lo;
    assign cmp_out    = cur.cm;
    assign shift_out  = cur.sh;
    assign carry_out  = cur.c | force_carry;
    assign arith_flag = (fn_r[3:2] == UNIT_ARITH && dly == 0 && flag_en[0]) || flag_force[0];
    assign logic_flag = (fn_r[3:2] == UNIT_LOGIC && dly == 0 && flag_en[1]) || flag_force[1];
    assign cmp_flag   = (fn_r[3:2] == UNIT_CMP   && dly == 0 && flag_en[2]) || flag_force[2];
    assign shift_flag = (fn_r[3:2] == UNIT_SHIFT && dly == 0 && flag_en[3]) || flag_force[3];

    int checks   = 0;
    int failures = 0;

    // Reference: result comes from the fn[3:2] unit unless its flag never shows within TIMEOUT WAIT cycles
    function automatic void model(input logic [3:0] fn, input logic [15:0] a, input logic [15:0] b,
                                  input int delay, input logic [3:0] en, input logic fc,
                                  output logic [31:0] d, output logic c, output logic e, output int lat);
        alu_res_t r;
        logic [1:0] u;
        r = alu_calc(fn, a, b);
        u = fn[3:2];
        if (!en[u] || delay > TIMEOUT) begin
            d = 32'h0; c = 1'b0; e = 1'b1; lat = TIMEOUT + 3;
        end else begin
            e = 1'b0; lat = 3 + delay; c = 1'b0;
            case (u)
                2'd0: begin d = r.arith; c = r.c | fc; end
                2'd1: d = {16'h0, r.lo};
                2'd2: d = {16'h0, r.cm};
                default: d = {16'h0, r.sh};
            endcase
        end
    endfunction

    task automatic run_op(input int id, input logic [3:0] fn, input logic [15:0] a, input logic [15:0] b,
                          output logic [3:0] iss_fn, output logic [15:0] iss_a, output logic [15:0] iss_b,
                          output logic iss_rdy, output int lat, output logic [31:0] d,
                          output logic c, output logic e, output logic rid, output bit to);
        int n;
        to = 1'b0; lat = 0; iss_fn = '0; iss_a = '0; iss_b = '0; iss_rdy = 1'b0;
        d = '0; c = 1'b0; e = 1'b0; rid = 1'b0;
        if (id == 0) begin
            bus.req0_fn = fn; bus.req0_a = a; bus.req0_b = b; bus.req0_valid = 1'b1;
        end else begin
            bus.req1_fn = fn; bus.req1_a = a; bus.req1_b = b; bus.req1_valid = 1'b1;
        end
        #1;
        n = 0;
        while (!(id == 0 ? bus.req0_ready : bus.req1_ready) && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 20) begin
            to = 1'b1;
            bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        lat = 1;
        iss_fn = alu_fn; iss_a = alu_A; iss_b = alu_B;
        iss_rdy = (id == 0) ? bus.req0_ready : bus.req1_ready;
        while (!bus.resp_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        if (!bus.resp_valid) begin
            to = 1'b1;
            return;
        end
        d = bus.resp_data; c = bus.resp_carry; e = bus.resp_err; rid = bus.resp_id;
        if (bus.resp_ready) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (bus.resp_valid !== 1'b0 || bus.resp_data !== 32'h0 || bus.resp_id !== 1'b0 ||
            bus.resp_carry !== 1'b0 || bus.resp_err !== 1'b0 || bus.req0_ready !== 1'b0 ||
            bus.req1_ready !== 1'b0 || alu_A !== 16'h0 || alu_B !== 16'h0 || alu_fn !== 4'h0) begin
            failures++;
            $display("FAIL reset_outputs got v=%b d=%h id=%b c=%b e=%b r0=%b r1=%b A=%h B=%h fn=%h exp all zero",
                     bus.resp_valid, bus.resp_data, bus.resp_id, bus.resp_carry, bus.resp_err,
                     bus.req0_ready, bus.req1_ready, alu_A, alu_B, alu_fn);
        end
        rst = 1'b0;
    endtask

    task automatic test_add();
        logic [3:0] ifn; logic [15:0] ia, ib; logic irdy, c, e, rid; logic [31:0] d; int lat; bit to;
        run_op(0, 4'b0000, 16'd300, 16'hFE0C, ifn, ia, ib, irdy, lat, d, c, e, rid, to);
        checks++;
        if (to || ifn !== 4'b0000 || ia !== 16'd300 || ib !== 16'hFE0C || irdy !== 1'b0) begin
            failures++;
            $display("FAIL add_issue got to=%b fn=%h A=%h B=%h rdy=%b exp fn=0 A=012c B=fe0c rdy=0", to, ifn, ia, ib, irdy);
        end
        checks++;
        if (lat !== 3 || d !== 32'hFFFF_FF38 || rid !== 1'b0 || e !== 1'b0 || c !== 1'b0) begin
            failures++;
            $display("FAIL add_resp got lat=%0d d=%h id=%b e=%b c=%b exp lat=3 d=ffffff38 id=0 e=0 c=0", lat, d, rid, e, c);
        end
    endtask

    task automatic test_round_robin();
        logic [15:0] a0, b0, a1, b1;
        int acc_id[4], acc_cyc[4];
        int k, rk, cyc;
        logic [31:0] exp_d;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        a0 = 16'($urandom); b0 = 16'($urandom); a1 = 16'($urandom); b1 = 16'($urandom);
        bus.req0_fn = 4'b0100; bus.req0_a = a0; bus.req0_b = b0; bus.req0_valid = 1'b1;
        bus.req1_fn = 4'b0100; bus.req1_a = a1; bus.req1_b = b1; bus.req1_valid = 1'b1;
        bus.resp_ready = 1'b1;
        k = 0; rk = 0; cyc = 0;
        #1;
        while ((k < 4 || rk < 4) && cyc < 60) begin
            if (k == 4) begin
                bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
            end
            if (bus.req0_ready && bus.req1_ready) begin
                checks++; failures++;
                $display("FAIL rr_both_ready got r0=1 r1=1 exp at most one");
            end
            if (k < 4 && (bus.req0_ready || bus.req1_ready)) begin
                acc_id[k] = bus.req1_ready ? 1 : 0;
                acc_cyc[k] = cyc;
                k++;
            end
            if (bus.resp_valid && rk < k) begin
                exp_d = {16'h0, (acc_id[rk] == 0) ? (a0 & b0) : (a1 & b1)};
                checks++;
                if (bus.resp_id !== acc_id[rk][0] || bus.resp_data !== exp_d || bus.resp_err !== 1'b0) begin
                    failures++;
                    $display("FAIL rr_resp[%0d] got id=%b d=%h e=%b exp id=%0d d=%h e=0",
                             rk, bus.resp_id, bus.resp_data, bus.resp_err, acc_id[rk], exp_d);
                end
                rk++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        checks++;
        if (k != 4 || rk != 4) begin
            failures++;
            $display("FAIL rr_count got accepts=%0d resps=%0d exp 4 and 4", k, rk);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (acc_id[i] != (i % 2) || (i > 0 && acc_cyc[i] - acc_cyc[i-1] != 4)) begin
                    failures++;
                    $display("FAIL rr_grant[%0d] got id=%0d gap=%0d exp id=%0d gap=4",
                             i, acc_id[i], (i > 0) ? acc_cyc[i] - acc_cyc[i-1] : 4, i % 2);
                end
            end
        end
    endtask

    task automatic test_resp_hold();
        logic [3:0] ifn, fn; logic [15:0] ia, ib, a, b; logic irdy, c, e, rid, ec, ee; logic [31:0] d, ed;
        int lat, el; bit to;
        fn = 4'b1100; a = 16'($urandom) | 16'h0001; b = 16'($urandom_range(1, 15));
        model(fn, a, b, 0, 4'hF, 1'b0, ed, ec, ee, el);
        bus.resp_ready = 1'b0;
        run_op(0, fn, a, b, ifn, ia, ib, irdy, lat, d, c, e, rid, to);
        checks++;
        if (to || d !== ed || c !== ec || e !== ee || rid !== 1'b0 || lat !== el) begin
            failures++;
            $display("FAIL hold_resp got to=%b d=%h c=%b e=%b id=%b lat=%0d exp d=%h c=%b e=%b id=0 lat=%0d",
                     to, d, c, e, rid, lat, ed, ec, ee, el);
        end
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.resp_valid !== 1'b1 || bus.resp_data !== ed || bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
                failures++;
                $display("FAIL hold_stable[%0d] got v=%b d=%h r0=%b r1=%b exp v=1 d=%h r0=0 r1=0",
                         i, bus.resp_valid, bus.resp_data, bus.req0_ready, bus.req1_ready, ed);
            end
        end
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.resp_valid !== 1'b0 || bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b1) begin
            failures++;
            $display("FAIL hold_release got v=%b r0=%b r1=%b exp v=0 r0=0 r1=1",
                     bus.resp_valid, bus.req0_ready, bus.req1_ready);
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    endtask

    task automatic test_timeout();
        logic [3:0] ifn; logic [15:0] ia, ib; logic irdy, c, e, rid; logic [31:0] d; int lat; bit to;
        flag_en = 4'hF & ~(4'b1 << UNIT_CMP);
        run_op(1, 4'b1000, 16'h0001, 16'h0002, ifn, ia, ib, irdy, lat, d, c, e, rid, to);
        checks++;
        if (to || e !== 1'b1 || d !== 32'h0 || c !== 1'b0 || rid !== 1'b1 || lat !== TIMEOUT + 3) begin
            failures++;
            $display("FAIL timeout_cmp got to=%b e=%b d=%h c=%b id=%b lat=%0d exp e=1 d=0 c=0 id=1 lat=%0d",
                     to, e, d, c, rid, lat, TIMEOUT + 3);
        end
        flag_en = 4'hF & ~(4'b1 << UNIT_ARITH);
        run_op(0, 4'b0000, 16'hFFFF, 16'h0001, ifn, ia, ib, irdy, lat, d, c, e, rid, to);
        checks++;
        if (to || e !== 1'b1 || d !== 32'h0 || c !== 1'b0) begin
            failures++;
            $display("FAIL timeout_arith got to=%b e=%b d=%h c=%b exp e=1 d=0 c=0", to, e, d, c);
        end
        flag_en = 4'hF;
        flag_delay = TIMEOUT;
        run_op(0, 4'b0110, 16'h00F0, 16'h0F0F, ifn, ia, ib, irdy, lat, d, c, e, rid, to);
        checks++;
        if (to || e !== 1'b0 || d !== 32'h0000_0FFF || lat !== TIMEOUT + 3) begin
            failures++;
            $display("FAIL flag_on_limit got to=%b e=%b d=%h lat=%0d exp e=0 d=00000fff lat=%0d",
                     to, e, d, lat, TIMEOUT + 3);
        end
        flag_delay = TIMEOUT + 1;
        run_op(1, 4'b0110, 16'h00F0, 16'h0F0F, ifn, ia, ib, irdy, lat, d, c, e, rid, to);
        checks++;
        if (to || e !== 1'b1 || d !== 32'h0 || lat !== TIMEOUT + 3) begin
            failures++;
            $display("FAIL flag_past_limit got to=%b e=%b d=%h lat=%0d exp e=1 d=0 lat=%0d",
                     to, e, d, lat, TIMEOUT + 3);
        end
        flag_delay = 0;
    endtask

    task automatic test_reset_mid();
        logic [3:0] ifn; logic [15:0] ia, ib; logic irdy, c, e, rid; logic [31:0] d; int lat, n; bit to, seen;
        flag_en = 4'h0;
        bus.req0_fn = 4'b0001; bus.req0_a = 16'($urandom) | 16'h0001; bus.req0_b = 16'h1234; bus.req0_valid = 1'b1;
        #1;
        n = 0;
        while (!bus.req0_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (n >= 20 || bus.resp_valid !== 1'b0 || bus.resp_data !== 32'h0 || bus.resp_id !== 1'b0 ||
            bus.resp_carry !== 1'b0 || bus.resp_err !== 1'b0 || bus.req0_ready !== 1'b0 ||
            bus.req1_ready !== 1'b0 || alu_A !== 16'h0 || alu_B !== 16'h0 || alu_fn !== 4'h0) begin
            failures++;
            $display("FAIL midreset_outputs got v=%b d=%h id=%b c=%b e=%b A=%h B=%h fn=%h exp all zero",
                     bus.resp_valid, bus.resp_data, bus.resp_id, bus.resp_carry, bus.resp_err, alu_A, alu_B, alu_fn);
        end
        seen = 1'b0;
        for (int i = 0; i < TIMEOUT + 6; i++) begin
            if (bus.resp_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL midreset_no_resp got resp_valid=1 exp 0");
        end
        flag_en = 4'hF;
        run_op(1, 4'b0010, 16'd7, 16'd9, ifn, ia, ib, irdy, lat, d, c, e, rid, to);
        checks++;
        if (to || lat !== 3 || rid !== 1'b1 || d !== 32'h0000_003F || e !== 1'b0 || c !== 1'b0) begin
            failures++;
            $display("FAIL midreset_next got to=%b lat=%0d id=%b d=%h e=%b c=%b exp lat=3 id=1 d=0000003f e=0 c=0",
                     to, lat, rid, d, e, c);
        end
    endtask

    task automatic test_spurious();
        logic [3:0] ifn; logic [15:0] ia, ib; logic irdy, c, e, rid; logic [31:0] d; int lat; bit to;
        flag_force = 4'b0001;
        force_carry = 1'b1;
        run_op(0, 4'b0110, 16'h8000, 16'h0001, ifn, ia, ib, irdy, lat, d, c, e, rid, to);
        checks++;
        if (to || d !== 32'h0000_8001 || c !== 1'b0 || e !== 1'b0 || lat !== 3) begin
            failures++;
            $display("FAIL spurious_flag got to=%b d=%h c=%b e=%b lat=%0d exp d=00008001 c=0 e=0 lat=3", to, d, c, e, lat);
        end
        flag_force = 4'h0;
        force_carry = 1'b0;
    endtask

    task automatic test_random();
        logic [3:0] ifn, fn, en; logic [15:0] ia, ib, a, b; logic irdy, c, e, rid, ec, ee; logic [31:0] d, ed;
        int lat, el, id, dl; bit to;
        for (int i = 0; i < 40; i++) begin
            fn = 4'($urandom); a = 16'($urandom); b = 16'($urandom);
            id = $urandom_range(0, 1);
            dl = $urandom_range(0, TIMEOUT + 1);
            en = ($urandom_range(0, 4) == 0) ? (4'hF & ~(4'b1 << fn[3:2])) : 4'hF;
            flag_en = en;
            flag_delay = dl;
            flag_force = 4'($urandom) & ~(4'b1 << fn[3:2]);
            force_carry = 1'($urandom);
            model(fn, a, b, dl, en, force_carry, ed, ec, ee, el);
            run_op(id, fn, a, b, ifn, ia, ib, irdy, lat, d, c, e, rid, to);
            checks++;
            if (to || ifn !== fn || ia !== a || ib !== b || d !== ed || c !== ec || e !== ee ||
                rid !== id[0] || lat !== el) begin
                failures++;
                $display("FAIL random[%0d] fn=%h a=%h b=%h got to=%b d=%h c=%b e=%b id=%b lat=%0d exp d=%h c=%b e=%b id=%0d lat=%0d",
                         i, fn, a, b, to, d, c, e, rid, lat, ed, ec, ee, id, el);
            end
        end
        flag_en = 4'hF; flag_delay = 0; flag_force = 4'h0; force_carry = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got no completion exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_fn = '0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b0; bus.req1_fn = '0; bus.req1_a = '0; bus.req1_b = '0;
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_add();
        test_round_robin();
        test_resp_hold();
        test_timeout();
        test_reset_mid();
        test_spurious();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
